// File: rtl/wheel_velocity.sv
// Mecanum inverse kinematics: (vx, vy, wz) -> four wheel angular-velocity setpoints.
// Sign-magnitude fixed point, one shared shift-add multiplier sequenced by an FSM.
module wheel_velocity #(
  parameter int                     DATAWIDTH_N  = 32,
  parameter int                     FRACTIONAL_Q = 15,
  parameter logic [DATAWIDTH_N-1:0] K_LXLY       = 32'd5407,
  parameter logic [DATAWIDTH_N-1:0] INV_R        = 32'd903840
) (
  input  logic                   WHEEL_VELOCITY_CLOCK_50,
  input  logic                   WHEEL_VELOCITY_Reset_InHigh,
  input  logic                   WHEEL_VELOCITY_start_InHigh,
  input  logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_VX_InBus,
  input  logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_VY_InBus,
  input  logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_WZ_InBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W1_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W2_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W3_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W4_OutBus,
  output logic                   WHEEL_VELOCITY_busy_Out,
  output logic                   WHEEL_VELOCITY_done_Out,
  output logic                   WHEEL_VELOCITY_overflow_Out
);

  localparam int N  = DATAWIDTH_N;
  localparam int M  = N - 1;
  localparam int PW = 2 * M;
  localparam int CW = $clog2(M);
  localparam logic [M-1:0] MAG_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_K, S_ADD, S_MUL_W1, S_MUL_W2, S_MUL_W3, S_MUL_W4, S_DONE
  } state_t;

  function automatic logic [N-1:0] norm(input logic [N-1:0] x);
    return (x[M-1:0] == '0) ? '0 : x;
  endfunction

  function automatic logic [N-1:0] neg(input logic [N-1:0] x);
    return {~x[N-1], x[M-1:0]};
  endfunction

  // Returns {overflow, result}; a magnitude carry saturates to all-ones.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [M:0]   sum;
    logic [M-1:0] mag;
    logic         sgn;
    logic         ovf;
    sum = '0;
    mag = '0;
    sgn = 1'b0;
    ovf = 1'b0;
    if (a[N-1] == b[N-1]) begin
      sum = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
      sgn = a[N-1];
      if (sum[M]) begin
        mag = MAG_MAX;
        ovf = 1'b1;
      end else begin
        mag = sum[M-1:0];
      end
    end else if (a[M-1:0] >= b[M-1:0]) begin
      mag = a[M-1:0] - b[M-1:0];
      sgn = a[N-1];
    end else begin
      mag = b[M-1:0] - a[M-1:0];
      sgn = b[N-1];
    end
    return {ovf, norm({sgn, mag})};
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   vx_q, vx_d, vy_q, vy_d, wz_q, wz_d, p_q, p_d;
  logic [N-1:0]   num1_q, num1_d, num2_q, num2_d, num3_q, num3_d, num4_q, num4_d;
  logic [N-1:0]   w1_q, w1_d, w2_q, w2_d, w3_q, w3_d, w4_q, w4_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

  logic [N-1:0]   op_a, op_b, mul_res;
  logic [PW-1:0]  partial, prod, shifted;
  logic [M-1:0]   mul_mag;
  logic           mul_ovf, mul_last, is_mul;
  logic [N:0]     a1, a2, n1, n2, n3, n4;

  // Shared multiplier: one magnitude bit of op_b per cycle, result formed on the last step.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      S_MUL_K:  begin op_a = K_LXLY; op_b = wz_q;  end
      S_MUL_W1: begin op_a = num1_q; op_b = INV_R; end
      S_MUL_W2: begin op_a = num2_q; op_b = INV_R; end
      S_MUL_W3: begin op_a = num3_q; op_b = INV_R; end
      S_MUL_W4: begin op_a = num4_q; op_b = INV_R; end
      default:  begin op_a = '0;     op_b = '0;    end
    endcase
    partial  = op_b[cnt_q] ? ({{M{1'b0}}, op_a[M-1:0]} << cnt_q) : '0;
    prod     = acc_q + partial;
    shifted  = prod >> FRACTIONAL_Q;
    mul_ovf  = |shifted[PW-1:M];
    mul_mag  = mul_ovf ? MAG_MAX : shifted[M-1:0];
    mul_res  = norm({op_a[N-1] ^ op_b[N-1], mul_mag});
    mul_last = (cnt_q == CW'(M - 1));
    is_mul   = (state_q == S_MUL_K) || (state_q == S_MUL_W1) || (state_q == S_MUL_W2) ||
               (state_q == S_MUL_W3) || (state_q == S_MUL_W4);
  end

  always_comb begin
    a1 = sm_add(vx_q, neg(vy_q));
    a2 = sm_add(vx_q, vy_q);
    n1 = sm_add(a1[N-1:0], neg(p_q));
    n2 = sm_add(a2[N-1:0], p_q);
    n3 = sm_add(a2[N-1:0], neg(p_q));
    n4 = sm_add(a1[N-1:0], p_q);
  end

  always_comb begin
    state_d = state_q;
    vx_d = vx_q;  vy_d = vy_q;  wz_d = wz_q;  p_d = p_q;
    num1_d = num1_q;  num2_d = num2_q;  num3_d = num3_q;  num4_d = num4_q;
    w1_d = w1_q;  w2_d = w2_q;  w3_d = w3_q;  w4_d = w4_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (is_mul) begin
      acc_d = mul_last ? '0 : prod;
      cnt_d = mul_last ? '0 : cnt_q + CW'(1);
      if (mul_last) ovf_d = ovf_q | mul_ovf;
    end
    // Each multiply result overwrites the numerator it consumed, so the outputs change only at DONE.
    case (state_q)
      S_IDLE: if (WHEEL_VELOCITY_start_InHigh) begin
        vx_d    = norm(WHEEL_VELOCITY_VX_InBus);
        vy_d    = norm(WHEEL_VELOCITY_VY_InBus);
        wz_d    = norm(WHEEL_VELOCITY_WZ_InBus);
        ovf_d   = 1'b0;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_MUL_K;
      end
      S_MUL_K: if (mul_last) begin
        p_d     = mul_res;
        state_d = S_ADD;
      end
      S_ADD: begin
        num1_d  = n1[N-1:0];
        num2_d  = n2[N-1:0];
        num3_d  = n3[N-1:0];
        num4_d  = n4[N-1:0];
        ovf_d   = ovf_q | a1[N] | a2[N] | n1[N] | n2[N] | n3[N] | n4[N];
        state_d = S_MUL_W1;
      end
      S_MUL_W1: if (mul_last) begin num1_d = mul_res; state_d = S_MUL_W2; end
      S_MUL_W2: if (mul_last) begin num2_d = mul_res; state_d = S_MUL_W3; end
      S_MUL_W3: if (mul_last) begin num3_d = mul_res; state_d = S_MUL_W4; end
      S_MUL_W4: if (mul_last) begin
        w1_d    = num1_q;
        w2_d    = num2_q;
        w3_d    = num3_q;
        w4_d    = mul_res;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge WHEEL_VELOCITY_CLOCK_50) begin
    if (WHEEL_VELOCITY_Reset_InHigh) begin
      state_q <= S_IDLE;
      vx_q <= '0;  vy_q <= '0;  wz_q <= '0;  p_q <= '0;
      num1_q <= '0;  num2_q <= '0;  num3_q <= '0;  num4_q <= '0;
      w1_q <= '0;  w2_q <= '0;  w3_q <= '0;  w4_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vx_q <= vx_d;  vy_q <= vy_d;  wz_q <= wz_d;  p_q <= p_d;
      num1_q <= num1_d;  num2_q <= num2_d;  num3_q <= num3_d;  num4_q <= num4_d;
      w1_q <= w1_d;  w2_q <= w2_d;  w3_q <= w3_d;  w4_q <= w4_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign WHEEL_VELOCITY_W1_OutBus    = w1_q;
  assign WHEEL_VELOCITY_W2_OutBus    = w2_q;
  assign WHEEL_VELOCITY_W3_OutBus    = w3_q;
  assign WHEEL_VELOCITY_W4_OutBus    = w4_q;
  assign WHEEL_VELOCITY_busy_Out     = busy_q;
  assign WHEEL_VELOCITY_done_Out     = done_q;
  assign WHEEL_VELOCITY_overflow_Out = ovf_q;

endmodule

// File: tb/tb_wheel_velocity.sv
// Directed bench for wheel_velocity: expected wheel speeds are queued at start and
// popped when done pulses; also covers latency, ignored restart and mid-run reset.
module tb_wheel_velocity;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] vx_in, vy_in, wz_in;
  logic [31:0] w1, w2, w3, w4;
  logic        busy, done, ovf;

  typedef struct {
    logic [31:0] w1, w2, w3, w4;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  wheel_velocity dut (
    .WHEEL_VELOCITY_CLOCK_50     (clk),
    .WHEEL_VELOCITY_Reset_InHigh (reset),
    .WHEEL_VELOCITY_start_InHigh (start),
    .WHEEL_VELOCITY_VX_InBus     (vx_in),
    .WHEEL_VELOCITY_VY_InBus     (vy_in),
    .WHEEL_VELOCITY_WZ_InBus     (wz_in),
    .WHEEL_VELOCITY_W1_OutBus    (w1),
    .WHEEL_VELOCITY_W2_OutBus    (w2),
    .WHEEL_VELOCITY_W3_OutBus    (w3),
    .WHEEL_VELOCITY_W4_OutBus    (w4),
    .WHEEL_VELOCITY_busy_Out     (busy),
    .WHEEL_VELOCITY_done_Out     (done),
    .WHEEL_VELOCITY_overflow_Out (ovf)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drives one start pulse (sampled on edge t0) and queues the expected result.
  task automatic applyStimulus(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] wz,
                               input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] e3, input logic [31:0] e4, input logic eovf);
    exp_t e;
    e.w1 = e1;  e.w2 = e2;  e.w3 = e3;  e.w4 = e4;  e.ovf = eovf;
    sb.push_back(e);
    vx_in = vx;
    vy_in = vy;
    wz_in = wz;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check32({tag, "_w1"}, w1, e.w1);
      check32({tag, "_w2"}, w2, e.w2);
      check32({tag, "_w3"}, w3, e.w3);
      check32({tag, "_w4"}, w4, e.w4);
      checkBit({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  // Full run: checks latency, busy around DONE, single done pulse; optional restart attempt.
  task automatic runOp(input string tag, input logic [31:0] vx, input logic [31:0] vy,
                       input logic [31:0] wz, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] e3, input logic [31:0] e4, input logic eovf,
                       input int retrig_at);
    int cyc = 0;
    int lat = -1;
    int dones = 0;
    applyStimulus(vx, vy, wz, e1, e2, e3, e4, eovf);
    while (cyc < 400 && lat < 0) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) checkBit({tag, "_busy_start"}, busy, 1'b1);
      if (cyc == retrig_at) begin
        checkBit({tag, "_busy_retrig"}, busy, 1'b1);
        vx_in = 32'h0001_0000;
        start = 1'b1;
      end
      if (done) begin
        lat = cyc;
        dones++;
        checkBit({tag, "_busy_done"}, busy, 1'b1);
        checkOutput(tag);
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_timeout observed=no_done expected=done", tag);
    end else begin
      check32({tag, "_latency"}, 32'(lat), 32'd156);
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        if (done) dones++;
        if (i == 0) checkBit({tag, "_busy_after"}, busy, 1'b0);
      end
      check32({tag, "_done_count"}, 32'(dones), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    vx_in = '0;
    vy_in = '0;
    wz_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_w1", w1, 32'h0);
    check32("reset_w4", w4, 32'h0);
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_done", done, 1'b0);
    checkBit("reset_ovf", ovf, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] pure vx");
    runOp("vx", 32'h0000_8000, 32'h0, 32'h0,
          32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 1'b0, 0);

    $display("[TB] pure vy");
    runOp("vy", 32'h0, 32'h0000_8000, 32'h0,
          32'h800D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 32'h800D_CAA0, 1'b0, 0);

    $display("[TB] pure wz");
    runOp("wz", 32'h0, 32'h0, 32'h0000_8000,
          32'h8002_4695, 32'h0002_4695, 32'h8002_4695, 32'h0002_4695, 1'b0, 0);

    $display("[TB] mixed vx vy wz");
    runOp("mix", 32'h0000_8000, 32'h0000_4000, 32'h0000_8000,
          32'h0004_9EBA, 32'h0016_F685, 32'h0012_695A, 32'h0009_2BE5, 1'b0, 0);

    $display("[TB] saturation");
    runOp("sat", 32'h7FFF_FFFF, 32'h0, 32'h0,
          32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 0);

    $display("[TB] overflow cleared by next start");
    runOp("clr", 32'h0000_8000, 32'h0, 32'h0,
          32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 1'b0, 0);

    $display("[TB] negative zero inputs");
    runOp("negz", 32'h8000_0000, 32'h8000_0000, 32'h0,
          32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);

    $display("[TB] restart while busy");
    runOp("retrig", 32'h0000_8000, 32'h0, 32'h0,
          32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 1'b0, 50);

    $display("[TB] reset mid-computation");
    begin
      int dones = 0;
      applyStimulus(32'h0000_8000, 32'h0000_4000, 32'h0000_8000,
                    32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      for (int c = 1; c < 80; c++) begin
        @(posedge clk);
        #1;
        if (done) dones++;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      check32("abort_w1", w1, 32'h0);
      check32("abort_w2", w2, 32'h0);
      checkBit("abort_busy", busy, 1'b0);
      checkBit("abort_done", done, 1'b0);
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        #1;
        if (done) dones++;
      end
      check32("abort_no_done", 32'(dones), 32'd0);
    end

    $display("[TB] run after abort");
    runOp("post", 32'h0000_8000, 32'h0, 32'h0,
          32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 32'h000D_CAA0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wheel_velocity.md
Name: wheel_velocity

Overview:
- Inverse-kinematics block for the mecanum base, the companion of the local-velocity (forward-kinematics) block.
- Converts a commanded local velocity (vx, vy [m/s], wz [rad/s]) into four wheel angular-velocity setpoints [rad/s] for the per-wheel PID loops.
- Equations, with K = lx+ly:
  - w1 = (vx − vy − K·wz)/r
  - w2 = (vx + vy + K·wz)/r
  - w3 = (vx + vy − K·wz)/r
  - w4 = (vx − vy + K·wz)/r
- Uses one shared iterative multiplier sequenced by an FSM; start/done handshake.

Parameters:
- DATAWIDTH_N, 32, word width. Sign-magnitude fixed point: MSB = sign, remaining bits = magnitude.
- FRACTIONAL_Q, 15, fractional bits.
- K_LXLY, 32'd5407, lx+ly in Q15 (≈0.165 m).
- INV_R, 32'd903840, 1/r in Q15 (≈27.583 1/m).

Ports:
- WHEEL_VELOCITY_CLOCK_50  in  1  system clock, 50 MHz
- WHEEL_VELOCITY_Reset_InHigh  in  1  synchronous active-high reset
- WHEEL_VELOCITY_start_InHigh  in  1  request a computation; sampled only in IDLE
- WHEEL_VELOCITY_VX_InBus  in  N  vx [m/s]
- WHEEL_VELOCITY_VY_InBus  in  N  vy [m/s]
- WHEEL_VELOCITY_WZ_InBus  in  N  wz [rad/s]
- WHEEL_VELOCITY_W1_OutBus  out  N  wheel 1 [rad/s]
- WHEEL_VELOCITY_W2_OutBus  out  N  wheel 2 [rad/s]
- WHEEL_VELOCITY_W3_OutBus  out  N  wheel 3 [rad/s]
- WHEEL_VELOCITY_W4_OutBus  out  N  wheel 4 [rad/s]
- WHEEL_VELOCITY_busy_Out  out  1  high while not in IDLE
- WHEEL_VELOCITY_done_Out  out  1  one-cycle pulse; outputs valid
- WHEEL_VELOCITY_overflow_Out  out  1  saturation occurred in the last computation

Behaviour:
- Interface: one clock, WHEEL_VELOCITY_CLOCK_50. Reset WHEEL_VELOCITY_Reset_InHigh is synchronous and active-high.
- Reset values: all W outputs 32'h0, busy 0, done 0, overflow 0, FSM in IDLE. Reset asserted mid-operation aborts the computation on that edge, with the same values; no done is produced.
- FSM states: IDLE → MUL_K → ADD → MUL_W1 → MUL_W2 → MUL_W3 → MUL_W4 → DONE → IDLE.
- IDLE: on an edge with start=1, latch vx/vy/wz, clear overflow, go to MUL_K. Later changes on the inputs have no effect on the computation.
- Start outside IDLE, including in DONE, is ignored; no queuing.
- MUL_K: P = K_LXLY·wz.
- ADD: form the four numerators vx∓vy∓P with sign-magnitude add/sub. Negation = MSB flip.
- MUL_Wi: Wi_result = numerator_i·INV_R.
- DONE: lasts 1 cycle with done=1; outputs hold until the next DONE or reset.
- Multiplier:
  - Shift-add over the N−1 magnitude bits; each MUL state lasts exactly N−1 cycles.
  - Result sign = XOR of the operand signs.
  - Magnitude = (ma·mb) >> FRACTIONAL_Q, truncated toward zero.
  - Any product bit above the N−1 kept magnitude bits → saturate magnitude to all-ones and set overflow.
- Adder: a magnitude carry-out saturates to all-ones and sets overflow.
- Negative zero: any zero-magnitude result (intermediate or output) is normalised to 32'h00000000. Input 32'h80000000 is treated as zero.
- Latency:
  - State timing: MUL_K is entered at the start edge t0; ADD at t0+(N−1); MUL_W4 exits at t0+5(N−1)+1.
  - done=1 and the new W outputs become visible right after edge t0+5(N−1)+1 (t0+156 for N=32).
  - W1–W4 update on that same edge.
- Minimum start-to-start spacing is 5(N−1)+3 cycles. busy is high from the edge after t0 through the end of DONE.
- overflow is sticky within a computation and cleared at the next accepted start.

Test Plan:
- Reset, then vx=0x00008000 (1.0), vy=0, wz=0, start pulse:
  - done exactly 156 cycles after the start edge.
  - W1..W4 = 0x000DCAA0; overflow=0.
- vx=0, vy=0x00008000, wz=0:
  - W1=0x800DCAA0, W2=0x000DCAA0, W3=0x000DCAA0, W4=0x800DCAA0.
- vx=0, vy=0, wz=0x00008000:
  - K·wz=0x0000151F.
  - W1=0x80024695, W2=0x00024695, W3=0x80024695, W4=0x00024695.
- vx=0x7FFFFFFF, vy=0, wz=0:
  - all outputs 0x7FFFFFFF, overflow=1.
  - A following start with vx=0x00008000 clears overflow to 0.
- vx=0x80000000, vy=0x80000000, wz=0:
  - all outputs 0x00000000, never 0x80000000.
- Start again at cycle 50 of a run: ignored, busy stays 1, a single done.
- Separate run: reset at cycle 80: outputs 0, busy 0, no done; a new start afterwards behaves as in scenario 1.
